// File: rtl/mem_interface_if.sv
// Bus between the control unit and the memory stage:
// strobes, address/data in, read data and status out.
interface mem_interface_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  Read;
  logic                  Write;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] DataIn;
  logic [DATA_WIDTH-1:0] Mdatain;
  logic                  Ready;
  logic                  Busy;
  logic                  Error;

  modport master (
    output Read, Write, Address, DataIn,
    input  Mdatain, Ready, Busy, Error
  );

  modport slave (
    input  Read, Write, Address, DataIn,
    output Mdatain, Ready, Busy, Error
  );
endinterface

// File: rtl/mem_interface.sv
// Memory stage: edge-triggered requests into a word RAM
// with a fixed number of wait states per access.
module mem_interface #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  mem_interface_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t                state_q;
  logic                  rd_q;
  logic                  wr_q;
  logic                  op_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] mdata_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  error_q;

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  logic rd_edge_d;
  logic wr_edge_d;
  logic do_op_d;

  assign rd_edge_d = bus.Read & ~rd_q;
  assign wr_edge_d = bus.Write & ~wr_q;
  assign do_op_d   = (state_q == ACCESS) && (cnt_q == 4'd0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= 4'd0;
      mdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      rd_q    <= bus.Read;
      wr_q    <= bus.Write;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rd_edge_d || wr_edge_d) begin
            if (bus.Read && bus.Write) begin
              error_q <= 1'b1;
            end else begin
              addr_q  <= bus.Address;
              data_q  <= bus.DataIn;
              op_wr_q <= wr_edge_d;
              cnt_q   <= 4'(WAIT_STATES);
              state_q <= ACCESS;
              busy_q  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!op_wr_q) mdata_q <= mem_q[addr_q];
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // No reset on the array: contents survive Reset, but an
  // aborted write never reaches it.
  always_ff @(posedge Clock) begin
    if (!Reset && do_op_d && op_wr_q) mem_q[addr_q] <= data_q;
  end

  assign bus.Mdatain = mdata_q;
  assign bus.Ready   = ready_q;
  assign bus.Busy    = busy_q;
  assign bus.Error   = error_q;
endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface: table vectors,
// hand-written corner sequences and a random phase.
module tb_mem_interface;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int WS = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_interface_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_interface #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WAIT_STATES(WS)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_m [2**AW];
  bit            vld_m [2**AW];
  logic [DW-1:0] exp_md = '0;

  typedef struct {
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            hold;
    logic [DW-1:0] exp_md;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One request; strobes held for 'hold' edges, bus scrambled after capture.
  task automatic access(input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int hold);
    int rdy;
    int rdy_at;
    int bsy;
    int errs;
    bit legal;
    rdy = 0; rdy_at = -1; bsy = 0; errs = 0;
    legal = (rd != wr);
    bus.Read = rd; bus.Write = wr; bus.Address = a; bus.DataIn = d;
    for (int n = 0; n < WS + 6; n++) begin
      @(negedge clk);
      if (bus.Ready === 1'b1) begin
        rdy++;
        if (rdy_at < 0) rdy_at = n;
      end
      if (bus.Busy === 1'b1) bsy++;
      if (bus.Error === 1'b1) errs++;
      if (n + 1 >= hold) begin bus.Read = 1'b0; bus.Write = 1'b0; end
      bus.Address = AW'($urandom); bus.DataIn = $urandom;
    end
    if (!legal) begin
      chk("err_pulses", 32'(errs), 32'(1));
      chk("err_busy", 32'(bsy), 32'(0));
      chk("err_ready", 32'(rdy), 32'(0));
    end else begin
      if (wr) begin mem_m[a] = d; vld_m[a] = 1'b1; end
      else exp_md = mem_m[a];
      chk("ready_pulses", 32'(rdy), 32'(1));
      chk("ready_cycle", 32'(rdy_at), 32'(WS + 1));
      chk("busy_cycles", 32'(bsy), 32'(WS + 2));
      chk("no_error", 32'(errs), 32'(0));
    end
    chk("mdatain", bus.Mdatain, exp_md);
  endtask

  initial begin
    bus.Read = 1'b0; bus.Write = 1'b0; bus.Address = '0; bus.DataIn = '0;
    for (int i = 0; i < 2**AW; i++) vld_m[i] = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 9'h05A, 32'hDEADBEEF, 1, 32'hCAFEF00D};
    vecs[1] = '{1'b1, 1'b0, 9'h05A, 32'h0,        1, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 9'h010, 32'h00000011, 1, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 9'h010, 32'h0,        6, 32'h00000011};
    vecs[4] = '{1'b1, 1'b1, 9'h010, 32'hFFFFFFFF, 1, 32'h00000011};
    vecs[5] = '{1'b1, 1'b0, 9'h010, 32'h0,        1, 32'h00000011};
    vecs[6] = '{1'b0, 1'b1, 9'h1FF, 32'h0BADF00D, 1, 32'h00000011};
    vecs[7] = '{1'b1, 1'b0, 9'h1FF, 32'h0,        1, 32'h0BADF00D};

    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mdatain", bus.Mdatain, 32'h0);
    chk("rst_ready", 32'(bus.Ready), 32'(0));
    chk("rst_busy", 32'(bus.Busy), 32'(0));
    chk("rst_error", 32'(bus.Error), 32'(0));

    // RAM survives reset
    access(1'b0, 1'b1, 9'h0AA, 32'hCAFEF00D, 1);
    access(1'b1, 1'b0, 9'h0AA, 32'h0, 1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    exp_md = '0;
    @(negedge clk);
    chk("rst2_mdatain", bus.Mdatain, 32'h0);
    chk("rst2_busy", 32'(bus.Busy), 32'(0));
    access(1'b1, 1'b0, 9'h0AA, 32'h0, 1);

    for (int i = 0; i < 8; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].hold);
      chk($sformatf("vec%0d_md", i), bus.Mdatain, vecs[i].exp_md);
    end

    // Reset on the cycle after capture discards the write
    bus.Write = 1'b1; bus.Address = 9'h1FF; bus.DataIn = 32'h12345678;
    @(negedge clk);
    chk("abort_busy_cap", 32'(bus.Busy), 32'(1));
    rst = 1'b1; bus.Write = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.Busy), 32'(0));
    chk("abort_ready", 32'(bus.Ready), 32'(0));
    rst = 1'b0;
    exp_md = '0;
    idle(2);
    access(1'b1, 1'b0, 9'h1FF, 32'h0, 1);
    chk("abort_keep", bus.Mdatain, 32'h0BADF00D);

    // Second read edge while busy is dropped
    access(1'b0, 1'b1, 9'h001, 32'h11111111, 1);
    access(1'b0, 1'b1, 9'h002, 32'h22222222, 1);
    begin
      int rdy;
      rdy = 0;
      bus.Read = 1'b1; bus.Address = 9'h001;
      @(negedge clk);
      bus.Read = 1'b0; bus.Address = 9'h002;
      @(negedge clk);
      bus.Read = 1'b1; bus.Address = 9'h002;
      for (int n = 0; n < 8; n++) begin
        @(negedge clk);
        if (bus.Ready === 1'b1) rdy++;
        bus.Read = 1'b0; bus.Address = AW'($urandom);
      end
      exp_md = mem_m[9'h001];
      chk("busy_ign_ready", 32'(rdy), 32'(1));
      chk("busy_ign_md", bus.Mdatain, exp_md);
      chk("busy_ign_idle", 32'(bus.Busy), 32'(0));
    end

    // Random traffic against the model
    for (int k = 0; k < 40; k++) begin
      int r;
      logic [AW-1:0] a;
      r = $urandom_range(0, 9);
      a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = a | 9'h100;
      if (r == 0)
        access(1'b1, 1'b1, a, $urandom, $urandom_range(1, 3));
      else if (r < 5 || !vld_m[a])
        access(1'b0, 1'b1, a, $urandom, $urandom_range(1, 3));
      else
        access(1'b1, 1'b0, a, 32'h0, $urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
